// File: rtl/pc_sequencer_if.sv
// Purpose : bundles every non-clock signal of the pc instruction-cycle sequencer.
// Modports: master - the sequencer (drives pc/memory/execute strobes and status)
//           slave  - the surrounding pc, instruction memory and execute unit
// Signals : run, pc_addr, instr_done, jump_req, jump_target, rupt_req, rupt_vec,
//           rupt_exit (toward sequencer); pc_en, pc_load, pc_load_addr,
//           fetch_strobe, ir_load, exec_start, rupt_ack, ret_addr, in_rupt,
//           state (from sequencer).
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              run;
  logic [ADDR_W-1:0] pc_addr;
  logic              instr_done;
  logic              jump_req;
  logic [ADDR_W-1:0] jump_target;
  logic              rupt_req;
  logic [2:0]        rupt_vec;
  logic              rupt_exit;

  logic              pc_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              fetch_strobe;
  logic              ir_load;
  logic              exec_start;
  logic              rupt_ack;
  logic [ADDR_W-1:0] ret_addr;
  logic              in_rupt;
  logic [2:0]        state;

  modport master (
    input  run, pc_addr, instr_done, jump_req, jump_target,
           rupt_req, rupt_vec, rupt_exit,
    output pc_en, pc_load, pc_load_addr, fetch_strobe, ir_load,
           exec_start, rupt_ack, ret_addr, in_rupt, state
  );

  modport slave (
    output run, pc_addr, instr_done, jump_req, jump_target,
           rupt_req, rupt_vec, rupt_exit,
    input  pc_en, pc_load, pc_load_addr, fetch_strobe, ir_load,
           exec_start, rupt_ack, ret_addr, in_rupt, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose : instruction-cycle controller for the pc program counter. Steps
//           IDLE/FETCH/WAIT/DECODE/EXEC/ADVANCE and issues the pc increment or
//           load plus memory / IR / execute strobes.
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - pc_sequencer_if.master (all handshake and status signals)
// Config  : define PC_SEQUENCER_RUPT_EN to enable interrupt entry/exit handling;
//           otherwise rupt_req/rupt_vec/rupt_exit are ignored and rupt_ack,
//           in_rupt, ret_addr are tied 0.
// Every strobe is registered from the next-state decision, so each strobe is
// high exactly during the cycle the FSM spends in the matching state.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       MEM_LAT   = 2,
  parameter logic [ADDR_W-1:0] RUPT_BASE = ADDR_W'('h800)
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    DECODE  = 3'd3,
    EXEC    = 3'd4,
    ADVANCE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_q, fetch_d;
  logic              ir_q, ir_d;
  logic              exec_q, exec_d;
  logic              pc_en_q, pc_en_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;

  // Interrupt hooks seen by the FSM; constant 0 when interrupts are compiled out.
  logic              take_rupt;
  logic              rupt_avail;
  logic [ADDR_W-1:0] rupt_addr;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fetch_q     <= 1'b0;
      ir_q        <= 1'b0;
      exec_q      <= 1'b0;
      pc_en_q     <= 1'b0;
      pc_load_q   <= 1'b0;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fetch_q     <= fetch_d;
      ir_q        <= ir_d;
      exec_q      <= exec_d;
      pc_en_q     <= pc_en_d;
      pc_load_q   <= pc_load_d;
      load_addr_q <= load_addr_d;
    end
  end

  // Next state and next outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fetch_d     = 1'b0;
    ir_d        = 1'b0;
    exec_d      = 1'b0;
    pc_en_d     = 1'b0;
    pc_load_d   = 1'b0;
    load_addr_d = load_addr_q;
    take_rupt   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = FETCH;
          fetch_d = 1'b1;
        end
      end
      FETCH: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DECODE;
          ir_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DECODE: begin
        state_d = EXEC;
        exec_d  = 1'b1;
      end
      EXEC: begin
        // pc action for ADVANCE is decided on the instr_done cycle so that the
        // registered pc_en/pc_load land exactly in the ADVANCE cycle.
        if (bus.instr_done) begin
          state_d = ADVANCE;
          if (rupt_avail) begin
            take_rupt   = 1'b1;
            pc_load_d   = 1'b1;
            load_addr_d = rupt_addr;
          end else if (bus.jump_req) begin
            pc_load_d   = 1'b1;
            load_addr_d = bus.jump_target;
          end else begin
            pc_en_d = 1'b1;
          end
        end
      end
      ADVANCE: begin
        if (bus.run) begin
          state_d = FETCH;
          fetch_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.fetch_strobe = fetch_q;
  assign bus.ir_load      = ir_q;
  assign bus.exec_start   = exec_q;
  assign bus.pc_en        = pc_en_q;
  assign bus.pc_load      = pc_load_q;
  assign bus.pc_load_addr = load_addr_q;

`ifdef PC_SEQUENCER_RUPT_EN
  logic              pending_q;
  logic [2:0]        vec_q;
  logic              in_rupt_q;
  logic              rupt_ack_q;
  logic [ADDR_W-1:0] ret_addr_q;
  logic              new_req;

  // A request is only accepted outside service; an exit in the same cycle wins.
  assign new_req    = bus.rupt_req & ~in_rupt_q & ~bus.rupt_exit;
  // A request arriving on the instr_done cycle itself is taken directly.
  assign rupt_avail = pending_q | new_req;
  assign rupt_addr  = RUPT_BASE + ADDR_W'({(pending_q ? vec_q : bus.rupt_vec), 2'b00});

  // Pending request, service flag and return address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 1'b0;
      vec_q      <= '0;
      in_rupt_q  <= 1'b0;
      rupt_ack_q <= 1'b0;
      ret_addr_q <= '0;
    end else begin
      rupt_ack_q <= take_rupt;
      if (take_rupt) begin
        pending_q  <= 1'b0;
        in_rupt_q  <= 1'b1;
        ret_addr_q <= bus.jump_req ? bus.jump_target : bus.pc_addr + ADDR_W'(1);
      end else begin
        if (new_req && !pending_q) begin
          pending_q <= 1'b1;
          vec_q     <= bus.rupt_vec;
        end
        if (bus.rupt_exit) in_rupt_q <= 1'b0;
      end
    end
  end

  assign bus.rupt_ack = rupt_ack_q;
  assign bus.in_rupt  = in_rupt_q;
  assign bus.ret_addr = ret_addr_q;
`else
  logic unused_rupt;

  assign rupt_avail  = 1'b0;
  assign rupt_addr   = '0;
  assign unused_rupt = ^{bus.rupt_req, bus.rupt_vec, bus.rupt_exit, take_rupt};

  assign bus.rupt_ack = 1'b0;
  assign bus.in_rupt  = 1'b0;
  assign bus.ret_addr = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed self-checking bench for pc_sequencer (MEM_LAT=2, ADDR_W=12).
// A small pc model follows pc_en/pc_load so pc_addr behaves like the real pc.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 12;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_WAIT = 3'd2,
                         S_DECODE = 3'd3, S_EXEC = 3'd4, S_ADV = 3'd5;
  // flag order: {fetch, ir_load, exec_start, pc_en, pc_load, rupt_ack, in_rupt}
  localparam logic [6:0] F_NONE = 7'b0000000, F_FETCH = 7'b1000000,
                         F_IR = 7'b0100000, F_EXEC = 7'b0010000,
                         F_INC = 7'b0001000, F_LOAD = 7'b0000100,
                         F_ACK = 7'b0000010, F_INR = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .MEM_LAT(2), .RUPT_BASE(12'h800)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // pc model
  logic [ADDR_W-1:0] pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc <= '0;
    else if (bus.pc_en)  pc <= pc + 12'd1;
    else if (bus.pc_load) pc <= bus.pc_load_addr;
  end
  assign bus.pc_addr = pc;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic logic [9:0] obs();
    return {bus.state, bus.fetch_strobe, bus.ir_load, bus.exec_start,
            bus.pc_en, bus.pc_load, bus.rupt_ack, bus.in_rupt};
  endfunction

  task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] fl);
    chk(tag, 32'(obs()), 32'({st, fl}));
  endtask

  // One full instruction with immediate instr_done, entered at a FETCH cycle.
  // inr is the in_rupt level expected before ADVANCE; adv the ADVANCE flags.
  task automatic instr(input string tag, input logic inr, input logic [6:0] adv,
                       input logic drop_rupt);
    logic [6:0] r;
    r = inr ? F_INR : F_NONE;
    cyc({tag, "_fetch"}, S_FETCH, F_FETCH | r); step();
    if (drop_rupt) bus.rupt_req = 1'b0;
    cyc({tag, "_wait1"}, S_WAIT, r); step();
    cyc({tag, "_wait2"}, S_WAIT, r); step();
    cyc({tag, "_decode"}, S_DECODE, F_IR | r); step();
    cyc({tag, "_exec"}, S_EXEC, F_EXEC | r); step();
    cyc({tag, "_adv"}, S_ADV, adv); step();
  endtask

  initial begin
    bus.run = 1'b0; bus.instr_done = 1'b1; bus.jump_req = 1'b0;
    bus.jump_target = '0; bus.rupt_req = 1'b0; bus.rupt_vec = '0; bus.rupt_exit = 1'b0;

    // Reset state
    step(); step();
    cyc("reset", S_IDLE, F_NONE);
    chk("reset_load_addr", 32'(bus.pc_load_addr), 32'h0);
    chk("reset_ret_addr", 32'(bus.ret_addr), 32'h0);
    rst_n = 1'b1;
    step();
    cyc("idle_no_run", S_IDLE, F_NONE);
    bus.run = 1'b1;
    step();

    // Plain increment, 6 cycles per instruction
    instr("inc0", 1'b0, F_INC, 1'b0);
    instr("inc1", 1'b0, F_INC, 1'b0);
    chk("pc_after_two", 32'(pc), 32'h002);

    // Jump
    bus.jump_req = 1'b1; bus.jump_target = 12'hAAA;
    instr("jump", 1'b0, F_LOAD, 1'b0);
    chk("jump_addr", 32'(bus.pc_load_addr), 32'hAAA);
    bus.jump_req = 1'b0; bus.jump_target = 12'h555;

    // EXEC stall, run dropped mid-instruction
    bus.instr_done = 1'b0;
    cyc("stall_fetch", S_FETCH, F_FETCH); step();
    bus.run = 1'b0;
    cyc("stall_wait1", S_WAIT, F_NONE); step();
    cyc("stall_wait2", S_WAIT, F_NONE); step();
    cyc("stall_decode", S_DECODE, F_IR); step();
    cyc("stall_exec1", S_EXEC, F_EXEC); step();
    cyc("stall_exec2", S_EXEC, F_NONE); step();
    bus.instr_done = 1'b1;
    cyc("stall_exec3", S_EXEC, F_NONE); step();
    cyc("stall_adv", S_ADV, F_INC);
    chk("load_addr_hold", 32'(bus.pc_load_addr), 32'hAAA);
    step();
    cyc("stop_idle1", S_IDLE, F_NONE); step();
    cyc("stop_idle2", S_IDLE, F_NONE);
    chk("pc_after_stall", 32'(pc), 32'hAAB);
    bus.run = 1'b1;
    step();

    // Async reset in WAIT
    cyc("rst_fetch", S_FETCH, F_FETCH); step();
    cyc("rst_wait", S_WAIT, F_NONE);
    #2 rst_n = 1'b0;
    #1 cyc("rst_async", S_IDLE, F_NONE);
    chk("rst_async_load_addr", 32'(bus.pc_load_addr), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    instr("post_rst", 1'b0, F_INC, 1'b0);

`ifdef PC_SEQUENCER_RUPT_EN
    // Interrupt vector 3 at pc 0x010
    bus.jump_req = 1'b1; bus.jump_target = 12'h010;
    instr("to010", 1'b0, F_LOAD, 1'b0);
    bus.jump_req = 1'b0;
    bus.rupt_req = 1'b1; bus.rupt_vec = 3'd3;
    instr("rupt3", 1'b0, F_LOAD | F_ACK | F_INR, 1'b1);
    chk("rupt3_vec", 32'(bus.pc_load_addr), 32'h80C);
    chk("rupt3_ret", 32'(bus.ret_addr), 32'h011);

    // Request while in service is ignored; taken after exit
    bus.rupt_req = 1'b1; bus.rupt_vec = 3'd1;
    instr("masked", 1'b1, F_INC | F_INR, 1'b0);
    chk("masked_ret_hold", 32'(bus.ret_addr), 32'h011);
    bus.rupt_exit = 1'b1;
    cyc("exit_fetch", S_FETCH, F_FETCH | F_INR); step();
    bus.rupt_exit = 1'b0;
    cyc("exit_wait1", S_WAIT, F_NONE); step();
    bus.rupt_req = 1'b0;
    cyc("exit_wait2", S_WAIT, F_NONE); step();
    cyc("exit_decode", S_DECODE, F_IR); step();
    cyc("exit_exec", S_EXEC, F_EXEC); step();
    cyc("exit_adv", S_ADV, F_LOAD | F_ACK | F_INR);
    chk("rupt1_vec", 32'(bus.pc_load_addr), 32'h804);
    chk("rupt1_ret", 32'(bus.ret_addr), 32'h80E);
    step();

    // Interrupt and jump in the same instruction
    bus.rupt_exit = 1'b1;
    cyc("exit2_fetch", S_FETCH, F_FETCH | F_INR); step();
    bus.rupt_exit = 1'b0; step(); step(); step(); step(); step();
    bus.rupt_req = 1'b1; bus.rupt_vec = 3'd2;
    bus.jump_req = 1'b1; bus.jump_target = 12'h123;
    instr("rupt_jump", 1'b0, F_LOAD | F_ACK | F_INR, 1'b1);
    chk("rupt_jump_vec", 32'(bus.pc_load_addr), 32'h808);
    chk("rupt_jump_ret", 32'(bus.ret_addr), 32'h123);
    bus.jump_req = 1'b0;

    // Return address wraps at the top of the address space
    bus.rupt_exit = 1'b1;
    cyc("exit3_fetch", S_FETCH, F_FETCH | F_INR); step();
    bus.rupt_exit = 1'b0; step(); step(); step(); step(); step();
    bus.jump_req = 1'b1; bus.jump_target = 12'hFFF;
    instr("toFFF", 1'b0, F_LOAD, 1'b0);
    bus.jump_req = 1'b0;
    bus.rupt_req = 1'b1; bus.rupt_vec = 3'd0;
    instr("rupt_wrap", 1'b0, F_LOAD | F_ACK | F_INR, 1'b1);
    chk("rupt_wrap_vec", 32'(bus.pc_load_addr), 32'h800);
    chk("rupt_wrap_ret", 32'(bus.ret_addr), 32'h000);
`else
    // Interrupt inputs have no effect
    bus.rupt_req = 1'b1; bus.rupt_vec = 3'd3; bus.rupt_exit = 1'b1;
    instr("rupt_off", 1'b0, F_INC, 1'b0);
    chk("rupt_off_ret", 32'(bus.ret_addr), 32'h0);
    chk("rupt_off_pc", 32'(pc), 32'h002);
    bus.rupt_req = 1'b0; bus.rupt_exit = 1'b0;
    // pc increment through the top of the address space
    bus.jump_req = 1'b1; bus.jump_target = 12'hFFF;
    instr("toFFF", 1'b0, F_LOAD, 1'b0);
    bus.jump_req = 1'b0;
    instr("wrap", 1'b0, F_INC, 1'b0);
    chk("wrap_pc", 32'(pc), 32'h000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
